// File: rtl/tile_pkg.sv
// Shared geometry constants, tile bitmap type, coordinate type and FSM states
// for the player-box physics engine.
package tile_pkg;

  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned MAP_ROWS   = 30;
  localparam int unsigned MAP_COLS   = 40;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned COORD_W    = 11;
  localparam int unsigned POS_W      = 10;
  localparam int unsigned VY_W       = 6;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned COL_W      = 6;

  typedef logic [0:MAP_ROWS-1][0:MAP_COLS-1] tile_map_t;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC_X  = 3'd1,
    S_CHECK_X = 3'd2,
    S_CALC_Y  = 3'd3,
    S_CHECK_Y = 3'd4,
    S_COMMIT  = 3'd5
  } state_e;

endpackage

// File: rtl/tile_probe.sv
// Combinational solid test for one pixel coordinate against the tile bitmap;
// anything off-screen (negative or past the right/bottom edge) is solid.
module tile_probe
  import tile_pkg::*;
(
  input  coord_t    x_i,
  input  coord_t    y_i,
  input  tile_map_t tile_i,
  output logic      solid_c,
  output logic      oob_c
);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  always_comb begin
    oob_c = x_i[COORD_W-1] | y_i[COORD_W-1]
          | (x_i[POS_W-1:0] >= POS_W'(SCREEN_W))
          | (y_i[POS_W-1:0] >= POS_W'(SCREEN_H));
    row     = y_i[TILE_SHIFT +: ROW_W];
    col     = x_i[TILE_SHIFT +: COL_W];
    solid_c = oob_c;
    // Index only when on-screen so row/col are guaranteed in range
    if (!oob_c) solid_c = tile_i[row][col];
  end

endmodule

// File: rtl/tile_physics.sv
// Per-frame motion/collision engine for the player box: applies keys and
// gravity on each vsync, resolves X then Y against the tile map one corner per clock.
module tile_physics
  import tile_pkg::*;
#(
  parameter int unsigned START_X  = 32,
  parameter int unsigned START_Y  = 32,
  parameter int unsigned SIZE     = 12,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned JUMP_V   = 10,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic             left,
  input  logic             right,
  input  logic             jump,
  input  tile_map_t        tile,
  output logic [POS_W-1:0] PosX,
  output logic [POS_W-1:0] PosY,
  output logic             on_ground,
  output logic             busy
);

  localparam coord_t SIZE_M1 = $signed(COORD_W'(SIZE - 1));
  localparam coord_t TILE_LO = $signed(COORD_W'((1 << TILE_SHIFT) - 1));
  localparam coord_t TILE_PX = $signed(COORD_W'(1 << TILE_SHIFT));
  localparam coord_t SPEED_C = $signed(COORD_W'(SPEED));

  state_e                  state_q, state_d;
  logic [2:0]              sync_q;
  logic                    fs_edge;
  logic [1:0]              corner_q, corner_d;
  coord_t                  vx_q, vx_d;
  coord_t                  cand_x_q, cand_x_d;
  coord_t                  cand_y_q, cand_y_d;
  logic signed [VY_W-1:0]  vy_q, vy_d, vy_n;
  logic signed [VY_W:0]    vy_sum;
  logic [POS_W-1:0]        res_x_q, res_x_d;
  logic [POS_W-1:0]        pos_x_q, pos_x_d;
  logic [POS_W-1:0]        pos_y_q, pos_y_d;
  logic                    hit_q, hit_d;
  logic                    oob_q, oob_d;
  logic                    gnd_q, gnd_d;
  logic                    busy_q, busy_d;
  coord_t                  probe_x, probe_y;
  coord_t                  right_edge, bottom_edge;
  logic                    probe_solid, probe_oob;
  logic                    vx_pos, vx_neg, vy_pos, vy_neg;

  // sync_q[1] is the synchronised vsync, sync_q[2] its previous value
  assign fs_edge = sync_q[1] & ~sync_q[2];

  assign right_edge  = cand_x_q + SIZE_M1;
  assign bottom_edge = cand_y_q + SIZE_M1;
  assign vx_pos = !vx_q[COORD_W-1] && (vx_q != '0);
  assign vx_neg = vx_q[COORD_W-1];
  assign vy_pos = !vy_q[VY_W-1] && (vy_q != '0);
  assign vy_neg = vy_q[VY_W-1];

  // Corner mux: bit 0 selects the right side, bit 1 the bottom side
  always_comb begin
    probe_x = (state_q == S_CHECK_Y) ? $signed({1'b0, res_x_q}) : cand_x_q;
    probe_y = (state_q == S_CHECK_Y) ? cand_y_q : $signed({1'b0, pos_y_q});
    if (corner_q[0]) probe_x = probe_x + SIZE_M1;
    if (corner_q[1]) probe_y = probe_y + SIZE_M1;
  end

  tile_probe u_probe (
    .x_i     (probe_x),
    .y_i     (probe_y),
    .tile_i  (tile),
    .solid_c (probe_solid),
    .oob_c   (probe_oob)
  );

  // Vertical velocity for this frame: jump impulse or clamped gravity
  always_comb begin
    vy_sum = $signed({vy_q[VY_W-1], vy_q}) + $signed((VY_W+1)'(GRAVITY));
    if (jump && gnd_q)
      vy_n = -$signed(VY_W'(JUMP_V));
    else if (vy_sum > $signed((VY_W+1)'(MAX_FALL)))
      vy_n = $signed(VY_W'(MAX_FALL));
    else
      vy_n = vy_sum[VY_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    corner_d = corner_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    res_x_d  = res_x_q;
    hit_d    = hit_q;
    oob_d    = oob_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    gnd_d    = gnd_q;

    unique case (state_q)
      S_IDLE: begin
        if (fs_edge) state_d = S_CALC_X;
      end
      S_CALC_X: begin
        unique case ({left, right})
          2'b01:   vx_d = SPEED_C;
          2'b10:   vx_d = -SPEED_C;
          default: vx_d = '0;
        endcase
        cand_x_d = $signed({1'b0, pos_x_q}) + vx_d;
        hit_d    = 1'b0;
        oob_d    = 1'b0;
        corner_d = 2'd0;
        state_d  = S_CHECK_X;
      end
      S_CHECK_X, S_CHECK_Y: begin
        hit_d    = hit_q | probe_solid;
        oob_d    = oob_q | probe_oob;
        corner_d = corner_q + 2'd1;
        if (corner_q == 2'd3)
          state_d = (state_q == S_CHECK_X) ? S_CALC_Y : S_COMMIT;
      end
      S_CALC_Y: begin
        // Snap against the tile edge that was hit; off-screen blocks hold position
        if (hit_q && !oob_q && vx_pos)
          res_x_d = POS_W'(right_edge & ~TILE_LO) - POS_W'(SIZE);
        else if (hit_q && !oob_q && vx_neg)
          res_x_d = POS_W'((cand_x_q & ~TILE_LO) + TILE_PX);
        else if (hit_q)
          res_x_d = pos_x_q;
        else
          res_x_d = cand_x_q[POS_W-1:0];
        vy_d     = vy_n;
        cand_y_d = $signed({1'b0, pos_y_q})
                 + $signed({{(COORD_W-VY_W){vy_n[VY_W-1]}}, vy_n});
        hit_d    = 1'b0;
        oob_d    = 1'b0;
        corner_d = 2'd0;
        state_d  = S_CHECK_Y;
      end
      S_COMMIT: begin
        pos_x_d = res_x_q;
        gnd_d   = 1'b0;
        if (hit_q && oob_q) begin
          vy_d  = '0;
          gnd_d = vy_pos;
        end else if (hit_q && vy_pos) begin
          pos_y_d = POS_W'(bottom_edge & ~TILE_LO) - POS_W'(SIZE);
          vy_d    = '0;
          gnd_d   = 1'b1;
        end else if (hit_q && vy_neg) begin
          pos_y_d = POS_W'((cand_y_q & ~TILE_LO) + TILE_PX);
          vy_d    = '0;
        end else if (!hit_q) begin
          pos_y_d = cand_y_q[POS_W-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      corner_q <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      res_x_q  <= '0;
      hit_q    <= 1'b0;
      oob_q    <= 1'b0;
      pos_x_q  <= POS_W'(START_X);
      pos_y_q  <= POS_W'(START_Y);
      gnd_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[1:0], frame_clk};
      corner_q <= corner_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      res_x_q  <= res_x_d;
      hit_q    <= hit_d;
      oob_q    <= oob_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      gnd_q    <= gnd_d;
      busy_q   <= busy_d;
    end
  end

  assign PosX      = pos_x_q;
  assign PosY      = pos_y_q;
  assign on_ground = gnd_q;
  assign busy      = busy_q;

endmodule
